// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester-side access bundle for the data-memory arbiter
//
// One instance per requester. The requester drives the master side and
// holds req with stable fields until it sees ack. The arbiter drives the
// slave side.

interface dm_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  sel;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] pc;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, sel, addr, wd, pc,
    input  ack, err, rdata
  );

  modport slave (
    input  req, we, sel, addr, wd, pc,
    output ack, err, rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port round-robin arbiter in front of the single-port data memory
//
// Port 0 is the CPU MEM stage, port 1 the debug/DMA master. Each grant
// performs exactly one access: IDLE -> SERVE (memory strobed) -> RESP (ack).
// A pending request on the other port is picked up directly from RESP, so
// alternating traffic costs two cycles per access.

module dm_arbiter #(
  parameter int unsigned DM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave p0,
  dm_arbiter_if.slave p1,
  output logic [1:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic [31:0] mem_pc_o,
  output logic [1:0]  mem_ls_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] LS_IDLE  = 2'b00;
  localparam logic [1:0] LS_LOAD  = 2'b01;
  localparam logic [1:0] LS_STORE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e      state_q;
  logic        cur_q;
  logic        last_q;
  logic        we_q;
  logic        bad_q;
  logic [1:0]  ack_q;
  logic [1:0]  err_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;
  logic [1:0]  mem_sel_q;
  logic [1:0]  mem_ls_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wd_q;
  logic [31:0] mem_pc_q;

  logic [1:0]  req_v;
  logic        gnt_d;
  logic        gnt_port_d;
  logic        we_d;
  logic        bad_d;
  logic [1:0]  sel_d;
  logic [31:0] addr_d;
  logic [31:0] wd_d;
  logic [31:0] pc_d;

  // Rejected accesses: illegal size, misaligned word/half, or past the end of memory.
  function automatic logic access_bad(input logic [1:0] sel, input logic [31:0] addr);
    logic b;
    b = (sel == 2'b11)
      || ((sel == 2'b00) && (addr[1:0] != 2'b00))
      || ((sel == 2'b01) && addr[0])
      || (addr >= 32'(DM_BYTES));
    return b;
  endfunction

  assign req_v = {p1.req, p0.req};

  // Choose the next port to latch: round-robin on a tie in IDLE; only the other port from RESP.
  always_comb begin
    gnt_d      = 1'b0;
    gnt_port_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_v[0] && req_v[1]) begin
          gnt_d      = 1'b1;
          gnt_port_d = ~last_q;
        end else if (req_v[0]) begin
          gnt_d      = 1'b1;
          gnt_port_d = 1'b0;
        end else if (req_v[1]) begin
          gnt_d      = 1'b1;
          gnt_port_d = 1'b1;
        end
      end
      ST_RESP: begin
        gnt_port_d = ~cur_q;
        gnt_d      = req_v[~cur_q];
      end
      default: begin
        gnt_d      = 1'b0;
        gnt_port_d = 1'b0;
      end
    endcase
  end

  // Request fields of the port being granted, plus its error verdict.
  always_comb begin
    if (gnt_port_d) begin
      we_d   = p1.we;
      sel_d  = p1.sel;
      addr_d = p1.addr;
      wd_d   = p1.wd;
      pc_d   = p1.pc;
    end else begin
      we_d   = p0.we;
      sel_d  = p0.sel;
      addr_d = p0.addr;
      wd_d   = p0.wd;
      pc_d   = p0.pc;
    end
    bad_d = access_bad(sel_d, addr_d);
  end

  // Arbiter FSM with registered memory strobes and per-port responses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cur_q      <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      bad_q      <= 1'b0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
      mem_sel_q  <= 2'b00;
      mem_ls_q   <= LS_IDLE;
      mem_addr_q <= 32'h0;
      mem_wd_q   <= 32'h0;
      mem_pc_q   <= 32'h0;
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (gnt_d) begin
            cur_q      <= gnt_port_d;
            we_q       <= we_d;
            bad_q      <= bad_d;
            mem_sel_q  <= sel_d;
            mem_addr_q <= addr_d;
            mem_wd_q   <= wd_d;
            mem_pc_q   <= pc_d;
            mem_ls_q   <= bad_d ? LS_IDLE : (we_d ? LS_STORE : LS_LOAD);
            state_q    <= ST_SERVE;
          end else begin
            mem_ls_q <= LS_IDLE;
            state_q  <= ST_IDLE;
          end
        end
        ST_SERVE: begin
          // Memory read data is only meaningful for a good load; everything else reports 0.
          if (cur_q) begin
            rdata1_q <= (!bad_q && !we_q) ? mem_rdata_i : 32'h0;
          end else begin
            rdata0_q <= (!bad_q && !we_q) ? mem_rdata_i : 32'h0;
          end
          err_q[cur_q] <= bad_q;
          ack_q[cur_q] <= 1'b1;
          last_q       <= cur_q;
          mem_ls_q     <= LS_IDLE;
          state_q      <= ST_RESP;
        end
        default: begin
          mem_ls_q <= LS_IDLE;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign p0.ack   = ack_q[0];
  assign p0.err   = err_q[0];
  assign p0.rdata = rdata0_q;
  assign p1.ack   = ack_q[1];
  assign p1.err   = err_q[1];
  assign p1.rdata = rdata1_q;

  assign mem_sel_o  = mem_sel_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_wd_o   = mem_wd_q;
  assign mem_pc_o   = mem_pc_q;
  // Gated by reset itself so a store caught mid-flight by reset never reaches the memory.
  assign mem_ls_o   = reset ? mem_ls_q : LS_IDLE;

endmodule
